// File: rtl/cpu_run_ctrl_pkg.sv
// Shared run-state encoding for the core run-state controller.
// The state value is exported on a port, so the encoding is fixed.
package cpu_run_ctrl_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        RUN   = 2'd0,
        SLEEP = 2'd1,
        WAKE  = 2'd2,
        HALT  = 2'd3
    } run_state_t;

endpackage

// File: rtl/cpu_run_ctrl_clk_en_divider.sv
// Clock-enable divider: one-cycle clk_en pulse every div_val+1 cycles.
// Latency: pulse is registered, first pulse div_val+1 edges after reset.
// No backpressure; free-running, div_val compared live so it never wraps.
module clk_en_divider #(
    parameter int DIV_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] div_val,
    output logic             clk_en
);

    localparam logic [DIV_W-1:0] CNT_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

    logic [DIV_W-1:0] cnt;

    // >= rather than == so a lowered div_val forces a pulse instead of wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            clk_en <= 1'b0;
        end else if (cnt >= div_val) begin
            cnt    <= '0;
            clk_en <= 1'b1;
        end else begin
            cnt    <= cnt + CNT_ONE;
            clk_en <= 1'b0;
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Core run-state controller: RUN/SLEEP/WAKE/HALT, pipeline freeze and EPC source select.
// Latency: state and registered outputs update one edge after a clk_en tick.
// No backpressure; events are sampled only on clk_en ticks.
module cpu_run_ctrl
    import cpu_run_ctrl_pkg::*;
#(
    parameter int NUM_IRQ  = 16,
    parameter int PC_W     = 32,
    parameter int DIV_W    = 32,
    parameter int CNT_W    = 32,
    parameter int WAKE_LAT = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [DIV_W-1:0]   div_val,
    input  logic               halt_req,
    input  logic               sleep_req,
    input  logic [PC_W-1:0]    sleep_pc_in,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic [NUM_IRQ-1:0] wake_mask,
    input  logic               irq_taken,
    input  logic               resume,
    output logic               clk_en,
    output logic               stall_all,
    output logic               halted,
    output logic               sleeping,
    output logic [PC_W-1:0]    sleep_pc,
    output logic               wake_pending,
    output logic [CNT_W-1:0]   sleep_cycles,
    output logic [STATE_W-1:0] state
);

    localparam int WCNT_W = (WAKE_LAT > 1) ? $clog2(WAKE_LAT) : 1;
    localparam logic [WCNT_W-1:0] WCNT_INIT = (WAKE_LAT > 0) ? WCNT_W'(WAKE_LAT - 1) : '0;
    localparam logic [WCNT_W-1:0] WCNT_ONE  = WCNT_W'(1);
    localparam logic [CNT_W-1:0]  CYC_ONE   = CNT_W'(1);

    run_state_t        state_q, state_d;
    logic [PC_W-1:0]   sleep_pc_d;
    logic              pend_d;
    logic [CNT_W-1:0]  cyc_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;

    clk_en_divider #(.DIV_W(DIV_W)) u_div (
        .clk     (clk),
        .rst_n   (rst_n),
        .div_val (div_val),
        .clk_en  (clk_en)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RUN;
            sleep_pc     <= '0;
            wake_pending <= 1'b0;
            sleep_cycles <= '0;
            wcnt_q       <= '0;
        end else begin
            state_q      <= state_d;
            sleep_pc     <= sleep_pc_d;
            wake_pending <= pend_d;
            sleep_cycles <= cyc_d;
            wcnt_q       <= wcnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sleep_pc_d = sleep_pc;
        pend_d     = wake_pending;
        cyc_d      = sleep_cycles;
        wcnt_d     = wcnt_q;
        if (clk_en) begin
            case (state_q)
                RUN: begin
                    if (halt_req) begin
                        state_d = HALT;
                    end else if (sleep_req) begin
                        state_d    = SLEEP;
                        sleep_pc_d = sleep_pc_in;
                        cyc_d      = '0;
                    end
                end
                SLEEP: begin
                    if (halt_req) begin
                        state_d = HALT;
                    end else begin
                        if (sleep_cycles != '1) begin
                            cyc_d = sleep_cycles + CYC_ONE;
                        end
                        if (|(irq & wake_mask)) begin
                            pend_d = 1'b1;
                            if (WAKE_LAT > 0) begin
                                state_d = WAKE;
                                wcnt_d  = WCNT_INIT;
                            end else begin
                                state_d = RUN;
                            end
                        end
                    end
                end
                WAKE: begin
                    if (halt_req) begin
                        state_d = HALT;
                    end else if (wcnt_q == '0) begin
                        state_d = RUN;
                    end else begin
                        wcnt_d = wcnt_q - WCNT_ONE;
                    end
                end
                HALT: begin
                    if (resume) begin
                        state_d = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
            // the handler entry retires the pending flag even if a wake lands on the same tick
            if (irq_taken) begin
                pend_d = 1'b0;
            end
        end
    end

    assign state     = state_q;
    assign stall_all = (state_q != RUN);
    assign halted    = (state_q == HALT);
    assign sleeping  = (state_q == SLEEP) || (state_q == WAKE);

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed-vector bench for cpu_run_ctrl; CNT_W=4 so sleep_cycles saturation is reachable.
module tb_cpu_run_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] div_val;
    logic        halt_req;
    logic        sleep_req;
    logic [31:0] sleep_pc_in;
    logic [15:0] irq;
    logic [15:0] wake_mask;
    logic        irq_taken;
    logic        resume;
    logic        clk_en;
    logic        stall_all;
    logic        halted;
    logic        sleeping;
    logic [31:0] sleep_pc;
    logic        wake_pending;
    logic [3:0]  sleep_cycles;
    logic [1:0]  state;

    int vectors     = 0;
    int miscompares = 0;

    cpu_run_ctrl #(
        .NUM_IRQ  (16),
        .PC_W     (32),
        .DIV_W    (32),
        .CNT_W    (4),
        .WAKE_LAT (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .div_val      (div_val),
        .halt_req     (halt_req),
        .sleep_req    (sleep_req),
        .sleep_pc_in  (sleep_pc_in),
        .irq          (irq),
        .wake_mask    (wake_mask),
        .irq_taken    (irq_taken),
        .resume       (resume),
        .clk_en       (clk_en),
        .stall_all    (stall_all),
        .halted       (halted),
        .sleeping     (sleeping),
        .sleep_pc     (sleep_pc),
        .wake_pending (wake_pending),
        .sleep_cycles (sleep_cycles),
        .state        (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " state"},        64'(state),        64'd0);
        chk({tag, " clk_en"},       64'(clk_en),       64'd0);
        chk({tag, " stall_all"},    64'(stall_all),    64'd0);
        chk({tag, " halted"},       64'(halted),       64'd0);
        chk({tag, " sleeping"},     64'(sleeping),     64'd0);
        chk({tag, " sleep_pc"},     64'(sleep_pc),     64'd0);
        chk({tag, " wake_pending"}, 64'(wake_pending), 64'd0);
        chk({tag, " sleep_cycles"}, 64'(sleep_cycles), 64'd0);
    endtask

    logic [15:0] en_trace;

    initial begin
        rst_n       = 1'b0;
        div_val     = 32'd3;
        halt_req    = 1'b0;
        sleep_req   = 1'b0;
        sleep_pc_in = '0;
        irq         = '0;
        wake_mask   = '0;
        irq_taken   = 1'b0;
        resume      = 1'b0;
        en_trace    = '0;

        #1;
        chk_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // divider period 4: pulse after edges 4, 8, 12, 16
        for (int i = 0; i < 16; i++) begin
            tick();
            en_trace[i] = clk_en;
        end
        chk("div3 pattern", 64'(en_trace), 64'h8888);
        tick();
        tick();
        chk("div3 midcount", 64'(clk_en), 64'd0);
        div_val = 32'd0;
        tick();
        chk("div lowered pulse", 64'(clk_en), 64'd1);
        tick();
        chk("div0 steady", 64'(clk_en), 64'd1);
        chk("still run", 64'(state), 64'd0);

        // enter SLEEP
        sleep_req   = 1'b1;
        sleep_pc_in = 32'h100;
        tick();
        sleep_req   = 1'b0;
        chk("sleep state",    64'(state),        64'd1);
        chk("sleep stall",    64'(stall_all),    64'd1);
        chk("sleep sleeping", 64'(sleeping),     64'd1);
        chk("sleep pc",       64'(sleep_pc),     64'h100);
        chk("sleep cyc0",     64'(sleep_cycles), 64'd0);

        // masked line does not wake
        irq       = 16'h0001;
        wake_mask = 16'hFFFE;
        tick();
        tick();
        chk("masked state", 64'(state),        64'd1);
        chk("masked cyc",   64'(sleep_cycles), 64'd2);
        chk("masked pend",  64'(wake_pending), 64'd0);

        // unmasked irq[5] wakes through WAKE for two ticks
        irq       = 16'h0020;
        wake_mask = 16'h0020;
        tick();
        irq = '0;
        chk("wake state",  64'(state),        64'd2);
        chk("wake pend",   64'(wake_pending), 64'd1);
        chk("wake sleep",  64'(sleeping),     64'd1);
        tick();
        chk("wake tick2",  64'(state),        64'd2);
        tick();
        chk("run after wake", 64'(state),     64'd0);
        chk("run stall",      64'(stall_all), 64'd0);
        chk("last cyc",       64'(sleep_cycles), 64'd3);

        // irq_taken clears pending
        irq_taken = 1'b1;
        tick();
        irq_taken = 1'b0;
        chk("pend cleared", 64'(wake_pending), 64'd0);

        // set and clear on the same tick: clear wins
        sleep_req   = 1'b1;
        sleep_pc_in = 32'h200;
        tick();
        sleep_req   = 1'b0;
        irq         = 16'h0020;
        irq_taken   = 1'b1;
        tick();
        irq         = '0;
        irq_taken   = 1'b0;
        chk("set+clr state", 64'(state),        64'd2);
        chk("set+clr pend",  64'(wake_pending), 64'd0);
        tick();
        tick();
        chk("run again", 64'(state), 64'd0);

        // halt beats sleep on the same tick
        halt_req    = 1'b1;
        sleep_req   = 1'b1;
        sleep_pc_in = 32'h300;
        tick();
        halt_req = 1'b0;
        irq      = 16'h0020;
        chk("halt state",  64'(state),    64'd3);
        chk("halt flag",   64'(halted),   64'd1);
        chk("halt pc",     64'(sleep_pc), 64'h200);
        tick();
        chk("halt sticky", 64'(state),    64'd3);
        sleep_req = 1'b0;
        irq       = '0;
        resume    = 1'b1;
        tick();
        resume = 1'b0;
        chk("resume run",   64'(state),  64'd0);
        chk("resume flag",  64'(halted), 64'd0);

        // CNT_W=4 saturation
        sleep_req   = 1'b1;
        sleep_pc_in = 32'h400;
        tick();
        sleep_req = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        chk("cyc at max", 64'(sleep_cycles), 64'hF);
        tick();
        chk("cyc saturate", 64'(sleep_cycles), 64'hF);
        chk("sat state",    64'(state),        64'd1);

        // async reset while sleeping with divider mid-count
        div_val = 32'd5;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async reset");
        @(negedge clk);
        rst_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
